alu_issue_ctrl: RTL
===================

// Module: alu_issue_ctrl
// PURPOSE
//  Command-side controller for the combinational alu: accepts op commands over valid/ready,
//  reads operands from a small local register file, drives alu A/B/op_code, captures
//  result + flags, writes back, returns a response over valid/ready. Sits between the core
//  sequencer and one alu instance; the alu itself is external.
// PARAMETERS
//  WIDTH   8  operand/result width; must equal the attached alu WIDTH
//  NREGS   4  register-file entries (power of 2)
//  REG_AW  2  register address width = log2(NREGS)
// PORTS
//  clk          in   1       single clock, all state on rising edge
//  rst          in   1       synchronous, active-high reset
//  cmd_valid    in   1       command present
//  cmd_ready    out  1       controller can accept command
//  cmd_op       in   4       op_code forwarded to alu (0000 ADD .. 0111 MUL)
//  cmd_rd       in   REG_AW  destination register
//  cmd_rs1      in   REG_AW  source for A
//  cmd_rs2      in   REG_AW  source for B (unless cmd_imm_sel)
//  cmd_imm_sel  in   1       1: B = cmd_imm instead of reg[cmd_rs2]
//  cmd_imm      in   WIDTH   immediate operand
//  wr_en        in   1       external register load
//  wr_addr      in   REG_AW  external load address
//  wr_data      in   WIDTH   external load data
//  flags_clr    in   1       clear sticky flags (used only with ALU_STICKY_FLAGS_EN)
//  alu_a        out  WIDTH   registered operand A to alu
//  alu_b        out  WIDTH   registered operand B to alu
//  alu_op_code  out  4       registered op_code to alu
//  alu_result   in   WIDTH   alu result
//  alu_zero/alu_negative/alu_carry/alu_overflow  in 1 each  alu flags
//  rsp_valid    out  1       response present
//  rsp_ready    in   1       consumer takes response
//  rsp_result   out  WIDTH   captured result
//  rsp_flags    out  4       {Z,N,C,V}
//  busy         out  1       state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE; all regs, flags, alu_a/alu_b/alu_op_code, rsp_result, rsp_flags = 0;
//    rsp_valid=0; cmd_ready=1; busy=0. Reset mid-op aborts: no write-back, response dropped.
//  - FSM IDLE -> EXEC -> RESP -> IDLE. cmd_ready = (state==IDLE), combinational from state.
//  - IDLE: on cmd_valid&cmd_ready at edge N: latch alu_a=reg[rs1], alu_b=imm_sel?imm:reg[rs2],
//    alu_op_code=cmd_op, rd; go EXEC. Operands use pre-edge register contents (no bypass).
//  - EXEC (cycle N+1, exactly one cycle): alu settles combinationally; at edge N+2 capture
//    rsp_result=alu_result, rsp_flags; reg[rd]=alu_result; go RESP. rsp_valid=1 from N+2.
//  - RESP: hold rsp_* stable while rsp_valid & !rsp_ready; on rsp_ready go IDLE; next command
//    accepted no earlier than the edge after the handshake. Throughput: 1 op per 3 cycles min.
//  - Undefined op (1000-1111): passed through unchanged; alu returns 0 -> flags Z=1,N=C=V=0;
//    reg[rd]=0 written; no error.
//  - External writes honoured in any state. Same-edge collision with write-back on same
//    address: write-back wins. Different addresses: both take effect.
//  - rs1==rs2==rd allowed; write-back affects only later commands.
//  - Width: all arithmetic done by alu; controller never extends or truncates data.
// CONFIGURATION
//  ALU_STICKY_FLAGS_EN defined: rsp_flags C and V are OR-accumulated across ops
//    (C<=C|alu_carry, V<=V|alu_overflow); Z,N always from latest op; flags_clr=1 clears C,V
//    at next edge (clear wins over same-edge set). Not defined: all four flags replaced each op,
//    flags_clr ignored.
// TESTING
//  - Load r1=0x7F, r2=0x01; ADD rd=3 -> rsp_result=0x80, rsp_flags=0101 (N,V), r3=0x80, rsp_valid at accept+2.
//  - r1=0x00, SUB imm_sel=1 imm=0x01 -> result 0xFF, flags 0110 (N,C); cmd_ready=0 until rsp handshake.
//  - Backpressure: rsp_ready=0 for 5 cycles -> rsp_result/rsp_flags stable, busy=1, cmd_valid ignored.
//  - Collision: write-back to r2 and wr_en r2=0x55 on same edge -> r2 holds alu result; op 1010 -> result 0x00, flags 1000.
//  - rst=1 during EXEC -> next cycle rsp_valid=0, rd register 0, all outputs at reset values.
//  - ADD 0xFF+0x01 (C=1) then AND 0x0F&0xF0: macro on -> flags 1010; macro off -> 1000; flags_clr then AND -> 1000.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//   Command-side controller for one external combinational alu. A command is
//   accepted in IDLE, its operands are read from a small local register file
//   and registered onto alu_a/alu_b/alu_op_code. After one EXEC cycle the alu
//   result and flags are captured into rsp_result/rsp_flags and written back
//   to reg[rd]. The response is then held in RESP until the consumer takes it.
//
//   Optional feature macro: ALU_STICKY_FLAGS_EN
//     defined     : C and V in rsp_flags accumulate (OR) across ops, Z and N
//                   come from the latest op, flags_clr clears C/V (clear wins)
//     not defined : all four flags are replaced by each op, flags_clr ignored
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   cmd_valid/cmd_ready      command handshake (ready only in IDLE)
//   cmd_op/rd/rs1/rs2        op_code and register addresses
//   cmd_imm_sel/cmd_imm      select immediate as operand B
//   wr_en/wr_addr/wr_data    external register load, honoured in any state
//   flags_clr                clear sticky C/V
//   alu_a/alu_b/alu_op_code  registered alu inputs
//   alu_result, alu_zero/negative/carry/overflow   alu outputs
//   rsp_valid/rsp_ready      response handshake
//   rsp_result/rsp_flags     captured result and {Z,N,C,V}
//   busy                     controller not in IDLE
module alu_issue_ctrl #(
  parameter int WIDTH  = 8,
  parameter int NREGS  = 4,
  parameter int REG_AW = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [REG_AW-1:0] cmd_rd,
  input  logic [REG_AW-1:0] cmd_rs1,
  input  logic [REG_AW-1:0] cmd_rs2,
  input  logic              cmd_imm_sel,
  input  logic [WIDTH-1:0]  cmd_imm,
  input  logic              wr_en,
  input  logic [REG_AW-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              flags_clr,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [3:0]        alu_op_code,
  input  logic [WIDTH-1:0]  alu_result,
  input  logic              alu_zero,
  input  logic              alu_negative,
  input  logic              alu_carry,
  input  logic              alu_overflow,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WIDTH-1:0]  rsp_result,
  output logic [3:0]        rsp_flags,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Everything latched at accept time; drives the alu during EXEC.
  typedef struct packed {
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic [3:0]        op;
    logic [REG_AW-1:0] rd;
  } issue_t;

  state_t                      state, state_nxt;
  issue_t                      iss_q;
  logic [NREGS-1:0][WIDTH-1:0] regs;
  logic                        accept;
  logic                        wb_en;
  logic [WIDTH-1:0]            opnd_b;
  logic [3:0]                  flags_nxt;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    wb_en     = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) state_nxt = EXEC;
      end
      EXEC: begin
        // alu settles during this single cycle; capture at its closing edge
        wb_en     = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = cmd_valid & cmd_ready;

  // ------------------------------------------------------ operand issue
  // Operands come from the pre-edge register contents: a write landing on
  // the accept edge is not forwarded.
  assign opnd_b = cmd_imm_sel ? cmd_imm : regs[cmd_rs2];

  always_ff @(posedge clk) begin
    if (rst) begin
      iss_q <= '0;
    end else if (accept) begin
      iss_q.a  <= regs[cmd_rs1];
      iss_q.b  <= opnd_b;
      iss_q.op <= cmd_op;
      iss_q.rd <= cmd_rd;
    end
  end

  assign alu_a       = iss_q.a;
  assign alu_b       = iss_q.b;
  assign alu_op_code = iss_q.op;

  // ------------------------------------------------------ register file
  // Write-back has priority over an external load to the same entry; loads
  // to other entries on the same edge still land.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (wb_en && (iss_q.rd == REG_AW'(i)))
          regs[i] <= alu_result;
        else if (wr_en && (wr_addr == REG_AW'(i)))
          regs[i] <= wr_data;
      end
    end
  end

  // ------------------------------------------------------- response regs
  always_comb begin
    flags_nxt = rsp_flags;
    if (wb_en)
      flags_nxt = {alu_zero, alu_negative, alu_carry, alu_overflow};
`ifdef ALU_STICKY_FLAGS_EN
    // C/V accumulate; clear is applied last so it wins over a same-edge set
    if (wb_en)
      flags_nxt[1:0] = rsp_flags[1:0] | {alu_carry, alu_overflow};
    if (flags_clr)
      flags_nxt[1:0] = 2'b00;
`endif
  end

`ifndef ALU_STICKY_FLAGS_EN
  logic unused_flags_clr;
  assign unused_flags_clr = flags_clr;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_result <= '0;
      rsp_flags  <= '0;
    end else begin
      if (wb_en) rsp_result <= alu_result;
      rsp_flags <= flags_nxt;
    end
  end

endmodule
